// File: rtl/clk_div_meter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// clk_div_meter_pkg - meter state type and period tolerance compare. Rev 1.0
// ---------------------------------------------------------------------------
package clk_div_meter_pkg;

  localparam int MAX_W = 32;

  typedef logic [MAX_W-1:0] wide_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  // Absolute difference is formed two bits wider than the operands so it cannot wrap.
  function automatic logic period_match(input wide_t p, input wide_t e, input wide_t tol);
    logic [MAX_W+1:0] diff;
    diff = (p >= e) ? ({2'b00, p} - {2'b00, e}) : ({2'b00, e} - {2'b00, p});
    return diff <= {2'b00, tol};
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_meter_sync_edge_det.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_edge_det - multi-flop synchroniser with rise/fall detect. Rev 1.0
// ---------------------------------------------------------------------------
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   level_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= '0;
      level_d <= 1'b0;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], d};
      level_d <= sync[SYNC_STAGES-1];
    end
  end

  assign level = sync[SYNC_STAGES-1];
  assign rise  = level & ~level_d;
  assign fall  = ~level & level_d;

endmodule
`default_nettype wire

// File: rtl/clk_div_meter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// clk_div_meter - measures high/low/period of a divided clock and tracks lock. Rev 1.0
// ---------------------------------------------------------------------------
module clk_div_meter
  import clk_div_meter_pkg::*;
#(
  parameter int W           = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CNT    = 4,
  parameter int TOL         = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         div_in,
  input  logic [W:0]   exp_period,
  output logic [W-1:0] high_len,
  output logic [W-1:0] low_len,
  output logic [W:0]   period,
  output logic         valid,
  output logic         locked,
  output logic         err,
  output logic         stalled
);

  localparam logic [W-1:0] RUN_MAX  = {W{1'b1}};
  localparam logic [W-1:0] RUN_ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [3:0]   LOCK_TGT = 4'(LOCK_CNT);

  logic         level;
  logic         rise;
  logic         fall;
  logic [W-1:0] run;
  logic [W-1:0] hi;
  logic [3:0]   mcnt;
  logic [3:0]   mcnt_inc;
  logic [W:0]   period_new;
  logic         match;
  state_t       state;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (div_in),
    .level(level),
    .rise (rise),
    .fall (fall)
  );

  assign period_new = {1'b0, hi} + {1'b0, run};
  assign match      = period_match(wide_t'(period_new), wide_t'(exp_period), wide_t'(TOL));
  assign mcnt_inc   = (mcnt == LOCK_TGT) ? mcnt : mcnt + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run      <= '0;
      hi       <= '0;
      mcnt     <= '0;
      state    <= IDLE;
      high_len <= '0;
      low_len  <= '0;
      period   <= '0;
      valid    <= 1'b0;
      locked   <= 1'b0;
      err      <= 1'b0;
      stalled  <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;

      if (rise || fall) begin
        run <= RUN_ONE;
      end else if (run != RUN_MAX) begin
        run <= run + RUN_ONE;
      end

      if (rise) begin
        stalled <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (rise) begin
            state <= HIGH;
          end
        end
        HIGH: begin
          if (fall) begin
            hi    <= run;
            state <= LOW;
          end else if (run == RUN_MAX && level) begin
            state   <= IDLE;
            stalled <= 1'b1;
            locked  <= 1'b0;
            mcnt    <= '0;
          end
        end
        LOW: begin
          if (rise) begin
            high_len <= hi;
            low_len  <= run;
            period   <= period_new;
            valid    <= 1'b1;
            state    <= HIGH;
            if (match) begin
              mcnt   <= mcnt_inc;
              locked <= (mcnt_inc == LOCK_TGT);
            end else begin
              mcnt   <= '0;
              locked <= 1'b0;
              err    <= 1'b1;
            end
          end else if (run == RUN_MAX && !level) begin
            state   <= IDLE;
            stalled <= 1'b1;
            locked  <= 1'b0;
            mcnt    <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_meter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_clk_div_meter - directed table-driven bench for clk_div_meter. Rev 1.0
// ---------------------------------------------------------------------------
module tb_clk_div_meter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       div_in = 1'b0;
  logic [8:0] exp_period = '0;
  logic [4:0] exp_a;

  logic [7:0] hl_m, ll_m;
  logic [8:0] per_m;
  logic       valid_m, locked_m, err_m, stalled_m;
  logic [3:0] hl_a, ll_a;
  logic [4:0] per_a;
  logic       valid_a, locked_a, err_a, stalled_a;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign exp_a = exp_period[4:0];

  clk_div_meter #(.W(8), .SYNC_STAGES(2), .LOCK_CNT(4), .TOL(0)) dut_m (
    .clk(clk), .rst_n(rst_n), .div_in(div_in), .exp_period(exp_period),
    .high_len(hl_m), .low_len(ll_m), .period(per_m), .valid(valid_m),
    .locked(locked_m), .err(err_m), .stalled(stalled_m)
  );

  clk_div_meter #(.W(4), .SYNC_STAGES(2), .LOCK_CNT(4), .TOL(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .div_in(div_in), .exp_period(exp_a),
    .high_len(hl_a), .low_len(ll_a), .period(per_a), .valid(valid_a),
    .locked(locked_a), .err(err_a), .stalled(stalled_a)
  );

  typedef struct {
    int hl; int ll; int per; int err; int lock; int cyc;
  } cap_t;

  cap_t q_m[$];
  cap_t q_a[$];
  cap_t c_m, c_a;

  always @(negedge clk) begin
    if (valid_m) begin
      c_m.hl = int'(hl_m); c_m.ll = int'(ll_m); c_m.per = int'(per_m);
      c_m.err = int'(err_m); c_m.lock = int'(locked_m); c_m.cyc = cyc;
      q_m.push_back(c_m);
    end
    if (valid_a) begin
      c_a.hl = int'(hl_a); c_a.ll = int'(ll_a); c_a.per = int'(per_a);
      c_a.err = int'(err_a); c_a.lock = int'(locked_a); c_a.cyc = cyc;
      q_a.push_back(c_a);
    end
  end

  typedef struct {
    int sec; int hn; int ln;
    int hl; int ll; int per;
    int err_m; int lock_m; int err_a; int lock_a;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs[NV];
  int   sec_exp[4] = '{6, 6, 6, 2};

  function automatic vec_t mkv(int sec, int hn, int ln, int hl, int ll, int per,
                               int em, int lm, int ea, int la);
    vec_t v;
    v.sec = sec; v.hn = hn; v.ln = ln; v.hl = hl; v.ll = ll; v.per = per;
    v.err_m = em; v.lock_m = lm; v.err_a = ea; v.lock_a = la;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic phase(input logic lvl, input int n);
    div_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    div_in = 1'b0;
    repeat (3) @(negedge clk);
    q_m.delete();
    q_a.delete();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    // Square 3/3, exp 6
    vecs[0]  = mkv(0, 3, 3, 3, 3, 6, 0, 0, 0, 0);
    vecs[1]  = mkv(0, 3, 3, 3, 3, 6, 0, 0, 0, 0);
    vecs[2]  = mkv(0, 3, 3, 3, 3, 6, 0, 0, 0, 0);
    vecs[3]  = mkv(0, 3, 3, 3, 3, 6, 0, 1, 0, 1);
    vecs[4]  = mkv(0, 3, 3, 3, 3, 6, 0, 1, 0, 1);
    vecs[5]  = mkv(0, 3, 3, 3, 3, 6, 0, 1, 0, 1);
    // Asymmetric 2/3 against exp 6: off by one, only the TOL=1 meter locks
    vecs[6]  = mkv(1, 2, 3, 2, 3, 5, 1, 0, 0, 0);
    vecs[7]  = mkv(1, 2, 3, 2, 3, 5, 1, 0, 0, 0);
    vecs[8]  = mkv(1, 2, 3, 2, 3, 5, 1, 0, 0, 0);
    vecs[9]  = mkv(1, 2, 3, 2, 3, 5, 1, 0, 0, 1);
    vecs[10] = mkv(1, 2, 3, 2, 3, 5, 1, 0, 0, 1);
    // Lock, one long period, relock
    vecs[11] = mkv(2, 3, 3, 3, 3, 6, 0, 0, 0, 0);
    vecs[12] = mkv(2, 3, 3, 3, 3, 6, 0, 0, 0, 0);
    vecs[13] = mkv(2, 3, 3, 3, 3, 6, 0, 0, 0, 0);
    vecs[14] = mkv(2, 3, 3, 3, 3, 6, 0, 1, 0, 1);
    vecs[15] = mkv(2, 3, 4, 3, 4, 7, 1, 0, 0, 1);
    vecs[16] = mkv(2, 3, 3, 3, 3, 6, 0, 0, 0, 1);
    vecs[17] = mkv(2, 3, 3, 3, 3, 6, 0, 0, 0, 1);
    vecs[18] = mkv(2, 3, 3, 3, 3, 6, 0, 0, 0, 1);
    vecs[19] = mkv(2, 3, 3, 3, 3, 6, 0, 1, 0, 1);
    // Single-cycle phases, exp 2
    vecs[20] = mkv(3, 1, 1, 1, 1, 2, 0, 0, 0, 0);
    vecs[21] = mkv(3, 1, 1, 1, 1, 2, 0, 0, 0, 0);
    vecs[22] = mkv(3, 1, 1, 1, 1, 2, 0, 0, 0, 0);
    vecs[23] = mkv(3, 1, 1, 1, 1, 2, 0, 1, 0, 1);
    vecs[24] = mkv(3, 1, 1, 1, 1, 2, 0, 1, 0, 1);

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_high_len", hl_m, 0);
    chk("rst_low_len", ll_m, 0);
    chk("rst_period", per_m, 0);
    chk("rst_valid", valid_m, 0);
    chk("rst_locked", locked_m, 0);
    chk("rst_err", err_m, 0);
    chk("rst_stalled", stalled_m, 0);
    rst_n = 1'b1;

    for (int s = 0; s < 4; s++) begin
      do_reset();
      exp_period = 9'(sec_exp[s]);
      phase(1'b0, 4);
      for (int i = 0; i < NV; i++) begin
        if (vecs[i].sec == s) begin
          phase(1'b1, vecs[i].hn);
          phase(1'b0, vecs[i].ln);
        end
      end
      phase(1'b1, 4);
      idx = 0;
      for (int i = 0; i < NV; i++) begin
        if (vecs[i].sec == s) begin
          if (idx < q_m.size()) begin
            chk($sformatf("s%0d_v%0d_high_len", s, idx), q_m[idx].hl, vecs[i].hl);
            chk($sformatf("s%0d_v%0d_low_len", s, idx), q_m[idx].ll, vecs[i].ll);
            chk($sformatf("s%0d_v%0d_period", s, idx), q_m[idx].per, vecs[i].per);
            chk($sformatf("s%0d_v%0d_err", s, idx), q_m[idx].err, vecs[i].err_m);
            chk($sformatf("s%0d_v%0d_locked", s, idx), q_m[idx].lock, vecs[i].lock_m);
            if (idx > 0)
              chk($sformatf("s%0d_v%0d_spacing", s, idx),
                  q_m[idx].cyc - q_m[idx-1].cyc, vecs[i].per);
          end
          if (idx < q_a.size()) begin
            chk($sformatf("s%0d_v%0d_tol_period", s, idx), q_a[idx].per, vecs[i].per);
            chk($sformatf("s%0d_v%0d_tol_err", s, idx), q_a[idx].err, vecs[i].err_a);
            chk($sformatf("s%0d_v%0d_tol_locked", s, idx), q_a[idx].lock, vecs[i].lock_a);
          end
          idx++;
        end
      end
      chk($sformatf("s%0d_valid_count", s), q_m.size(), idx);
      chk($sformatf("s%0d_tol_valid_count", s), q_a.size(), idx);
      chk($sformatf("s%0d_stalled", s), stalled_m, 0);
    end

    // Stall on the W=4 meter: lock first, then hold high 20 cycles
    do_reset();
    exp_period = 9'd6;
    phase(1'b0, 4);
    repeat (4) begin
      phase(1'b1, 3);
      phase(1'b0, 3);
    end
    div_in = 1'b1;
    repeat (10) @(negedge clk);
    chk("stall_pre_locked", locked_a, 1);
    repeat (7) @(negedge clk);
    chk("stall_not_yet", stalled_a, 0);
    @(negedge clk);
    chk("stall_set", stalled_a, 1);
    chk("stall_locked_clr", locked_a, 0);
    repeat (2) @(negedge clk);
    chk("stall_valid_count", q_a.size(), 4);
    chk("stall_w8_none", stalled_m, 0);
    phase(1'b0, 3);
    chk("stall_fall_holds", stalled_a, 1);
    div_in = 1'b1;
    repeat (2) @(negedge clk);
    chk("stall_pre_clear", stalled_a, 1);
    @(negedge clk);
    chk("stall_clear_on_rise", stalled_a, 0);
    phase(1'b0, 3);
    chk("resume_no_valid", q_a.size(), 4);
    phase(1'b1, 4);
    chk("resume_valid_count", q_a.size(), 5);
    if (q_a.size() == 5) begin
      chk("resume_high_len", q_a[4].hl, 3);
      chk("resume_low_len", q_a[4].ll, 3);
      chk("resume_period", q_a[4].per, 6);
      chk("resume_locked", q_a[4].lock, 0);
    end

    // Reset in the middle of a LOW phase while locked
    do_reset();
    exp_period = 9'd6;
    phase(1'b0, 4);
    repeat (4) begin
      phase(1'b1, 3);
      phase(1'b0, 3);
    end
    phase(1'b1, 3);
    div_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_pre_locked", locked_m, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_high_len", hl_m, 0);
    chk("midrst_low_len", ll_m, 0);
    chk("midrst_period", per_m, 0);
    chk("midrst_valid", valid_m, 0);
    chk("midrst_locked", locked_m, 0);
    chk("midrst_err", err_m, 0);
    chk("midrst_stalled", stalled_m, 0);
    @(negedge clk);
    rst_n = 1'b1;
    q_m.delete();
    phase(1'b0, 3);
    phase(1'b1, 3);
    chk("midrst_first_rise_no_valid", q_m.size(), 0);
    phase(1'b0, 4);
    div_in = 1'b1;
    repeat (2) @(negedge clk);
    chk("latency_pre", valid_m, 0);
    @(negedge clk);
    chk("latency_valid", valid_m, 1);
    chk("midrst_high_len_new", hl_m, 3);
    chk("midrst_low_len_new", ll_m, 4);
    chk("midrst_period_new", per_m, 7);
    chk("midrst_err_new", err_m, 1);
    chk("midrst_locked_new", locked_m, 0);
    @(negedge clk);
    chk("valid_one_cycle", valid_m, 0);
    chk("err_one_cycle", err_m, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clk_div_meter.md
Name: clk_div_meter

Overview:
- Measures a divided clock, such as the output of the team's integer clock divider, using a faster system clock.
- Reports high-phase length, low-phase length and period in clk cycles.
- Checks the period against an expected value and declares lock after consecutive matches.
- Used as the on-chip checker for divider outputs and as a frequency-ratio monitor.

Parameters:
- W, 8: width of the phase counters; high_len and low_len are W bits, period is W+1 bits.
- SYNC_STAGES, 2: flops in the input synchroniser chain (minimum 2).
- LOCK_CNT, 4: consecutive matching periods required to assert locked (1..15).
- TOL, 0: allowed absolute period error in clk cycles.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- div_in  input  1  divided clock under test; asynchronous to clk.
- exp_period  input  W+1  expected period in clk cycles; sampled at each period publish.
- high_len  output  W  last measured high-phase length.
- low_len  output  W  last measured low-phase length.
- period  output  W+1  high_len + low_len of the last complete period.
- valid  output  1  one-cycle pulse when high_len, low_len and period update.
- locked  output  1  LOCK_CNT consecutive periods within TOL of exp_period.
- err  output  1  one-cycle pulse, concurrent with valid, when the period is outside tolerance.
- stalled  output  1  level; div_in has had no edge for 2^W-1 cycles; cleared by the next rising edge.

Behaviour:
- Reset: all outputs 0, match counter 0, run counter 0, state IDLE. Synchroniser flops reset to 0.
- Input path:
  - div_in passes through SYNC_STAGES flops to give s, then one more flop gives s_d.
  - rise = s & ~s_d; fall = ~s & s_d.
- Run counter:
  - Loads 1 on any rise or fall.
  - Otherwise increments each cycle, saturating at 2^W-1.
  - A phase held for N clk cycles therefore measures exactly N.
- States:
  - IDLE: ignore fall; on rise, load run counter and go to HIGH. No publish.
  - HIGH: on fall, latch run counter into an internal hi register and go to LOW.
  - LOW: on rise, publish and go to HIGH. Publish means:
    - high_len <= hi; low_len <= run counter; period <= hi + run counter (W+1 bits, no overflow).
    - valid pulses; the run counter reloads.
  - Timeout: in HIGH or LOW, if the run counter is at 2^W-1 and no edge occurs, go to IDLE.
    - Set stalled; clear locked and the match counter.
    - No valid; high_len, low_len and period hold.
- Lock logic, evaluated only at publish:
  - Match if |period_new - exp_period| <= TOL.
  - On match, the match counter increments, saturating at LOCK_CNT; locked asserts in the same cycle as the valid on which the counter reaches LOCK_CNT.
  - On mismatch, err pulses, the match counter clears to 0, and locked deasserts in the same cycle as the valid.
- Latency: a div_in transition becomes visible in s after SYNC_STAGES clk edges. valid rises on the clk edge following the one where rise is detected. The total is SYNC_STAGES+1 clk edges after the first edge that samples the new level.
- Minimum measurable phase is 1 cycle. A div_in pulse shorter than one clk cycle may be missed; this is not an error, as the measured lengths absorb it.
- stalled clears on the next rise, not on a fall.
- Reset mid-operation: rst_n low immediately forces the reset state. The partial period is discarded, and the first rise after reset starts a fresh measurement with no publish.
- exp_period changing between publishes is legal; only the value present at publish matters.

Decomposition:
- Package clk_div_meter_pkg:
  - enum state_t {IDLE, HIGH, LOW}.
  - Function period_match(period, exp, tol) doing an absolute-difference compare at W+2 bits to avoid wrap.
- Sub-module sync_edge_det:
  - Parameter SYNC_STAGES; ports clk, rst_n, d.
  - Outputs level, rise, fall.
  - Reusable for other asynchronous-input monitors.

Test Plan:
- Square wave, div_in high 3 / low 3 clk cycles, exp_period=6, TOL=0 -> after the first full period, valid every 6 cycles with high_len=3, low_len=3, period=6; locked on the 4th valid; err never.
- Asymmetric wave, high 2 / low 3, exp_period=6, TOL=0 -> each valid reports period=5 with err; locked stays 0. Same stimulus with TOL=1 -> locked after 4 periods.
- Locked at 3/3, then one period of 3/4 -> err pulses with period=7 and locked drops on that valid. Four further 3/3 periods -> locked again.
- W=4, div_in held high for 20 cycles after a rise -> stalled=1 at run count 15, locked=0, no valid. Resuming 3/3 -> stalled clears at the first rise, and the first valid comes one period later.
- rst_n pulsed low in the middle of a LOW phase while locked -> all outputs 0 immediately. The first post-reset rise gives no valid; the next rise gives valid with correct lengths.
- Single-cycle phases, high 1 / low 1, exp_period=2 -> high_len=1, low_len=1, period=2 every 2 cycles; locked after 4.
